// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC read path types and default constants
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2,
    READ      = 2'd3
  } state_t;

  localparam int ADC_DATA_W = 8;
  localparam logic [ADC_DATA_W-1:0] ADC_VREF = 8'd128;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous ADC pins
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_read_ctrl.sv
// rtl/adc_read_ctrl.sv - tracks ADC BUSY after each convst fall, strobes the read and latches sample/error
module adc_read_ctrl
  import adc_pkg::*;
#(
  parameter int                DATA_W    = ADC_DATA_W,
  parameter int                RD_CYCLES = 2,
  parameter int                TIMEOUT   = 63,
  parameter logic [DATA_W-1:0] VREF      = ADC_VREF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              convst_bar,
  input  logic              busy,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              flag_clr,
  output logic              cs_bar,
  output logic              rd_bar,
  output logic [DATA_W-1:0] sample,
  output logic [DATA_W:0]   error,
  output logic              sample_valid,
  output logic              timeout_err,
  output logic              overrun_err
);

  // One timer serves both the BUSY waits and the read strobe length.
  localparam int TW_RAW = $clog2(max_int(TIMEOUT, RD_CYCLES - 1) + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] RD_LAST = TW'(RD_CYCLES - 1);

  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic              convst_q;
  logic              start;
  logic              busy_s;
  logic              cs_n, rd_n, valid_n, terr_n, oerr_n;
  logic [DATA_W-1:0] sample_n;
  logic [DATA_W:0]   error_n;

  sync_2ff #(.W(1)) u_busy_sync (
    .clk (clk),
    .rst (rst),
    .d   (busy),
    .q   (busy_s)
  );

  assign start = convst_q & ~convst_bar;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      convst_q     <= 1'b1;
      cs_bar       <= 1'b1;
      rd_bar       <= 1'b1;
      sample       <= '0;
      error        <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      convst_q     <= convst_bar;
      cs_bar       <= cs_n;
      rd_bar       <= rd_n;
      sample       <= sample_n;
      error        <= error_n;
      sample_valid <= valid_n;
      timeout_err  <= terr_n;
      overrun_err  <= oerr_n;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    cs_n     = cs_bar;
    rd_n     = rd_bar;
    sample_n = sample;
    error_n  = error;
    valid_n  = 1'b0;
    // Sticky flags: clear first so a same-cycle set event wins.
    terr_n   = flag_clr ? 1'b0 : timeout_err;
    oerr_n   = flag_clr ? 1'b0 : overrun_err;

    if (start && (state != IDLE)) oerr_n = 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = WAIT_RISE;
          timer_n = '0;
        end
      end
      WAIT_RISE: begin
        if (busy_s) begin
          state_n = WAIT_FALL;
          timer_n = '0;
        end else if (timer == T_MAX) begin
          state_n = IDLE;
          terr_n  = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      WAIT_FALL: begin
        if (!busy_s) begin
          state_n = READ;
          timer_n = '0;
          cs_n    = 1'b0;
          rd_n    = 1'b0;
        end else if (timer == T_MAX) begin
          state_n = IDLE;
          terr_n  = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      READ: begin
        if (timer == RD_LAST) begin
          sample_n = adc_data;
          error_n  = {1'b0, VREF} - {1'b0, adc_data};
          valid_n  = 1'b1;
          cs_n     = 1'b1;
          rd_n     = 1'b1;
          state_n  = IDLE;
          timer_n  = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_read_ctrl.sv
// tb/tb_adc_read_ctrl.sv - directed scoreboard bench for adc_read_ctrl
module tb_adc_read_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       convst_bar;
  logic       busy;
  logic [7:0] adc_data;
  logic       flag_clr;
  logic       cs_bar;
  logic       rd_bar;
  logic [7:0] sample;
  logic [8:0] error;
  logic       sample_valid;
  logic       timeout_err;
  logic       overrun_err;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int rd_cnt = 0;
  int vc0;
  logic [7:0] sb_q[$];
  logic [7:0] held;

  adc_read_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .convst_bar   (convst_bar),
    .busy         (busy),
    .adc_data     (adc_data),
    .flag_clr     (flag_clr),
    .cs_bar       (cs_bar),
    .rd_bar       (rd_bar),
    .sample       (sample),
    .error        (error),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err),
    .overrun_err  (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_err(input int d);
    return 9'(128 - d);
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic conv(input logic [7:0] d, input int dly, input int len, input bit push);
    adc_data = d;
    if (push) sb_q.push_back(d);
    convst_bar = 1'b0;
    tick;
    convst_bar = 1'b1;
    repeat (dly) tick;
    busy = 1'b1;
    repeat (len) tick;
    busy = 1'b0;
    repeat (10) tick;
  endtask

  // Scoreboard and read-strobe monitor
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0;
    end else begin
      if (cs_bar !== rd_bar) chk("cs_eq_rd", 32'(cs_bar), 32'(rd_bar));
      if (sample_valid) begin
        valid_cnt++;
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          held = sb_q.pop_front();
          chk("sample", 32'(sample), 32'(held));
          chk("error", 32'(error), 32'(exp_err(int'(held))));
        end
      end
      if (rd_bar === 1'b0) begin
        rd_cnt++;
      end else if (rd_cnt != 0) begin
        chk("rd_low_len", rd_cnt, 32'd2);
        rd_cnt = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; convst_bar = 1'b1; busy = 1'b0; adc_data = 8'd0; flag_clr = 1'b0;
    repeat (3) tick;
    chk("rst_cs", 32'(cs_bar), 32'd1);
    chk("rst_rd", 32'(rd_bar), 32'd1);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_oerr", 32'(overrun_err), 32'd0);
    rst = 1'b0;
    tick;

    // Nominal
    conv(8'd200, 10, 20, 1'b1);
    chk("nom_valid_cnt", valid_cnt, 32'd1);
    chk("nom_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("nom_sample", 32'(sample), 32'd200);
    chk("nom_error", 32'(error), 32'h1B8);
    chk("nom_terr", 32'(timeout_err), 32'd0);
    chk("nom_oerr", 32'(overrun_err), 32'd0);

    // Error sign extremes
    conv(8'd0, 3, 8, 1'b1);
    chk("e0_error", 32'(error), 32'h080);
    conv(8'd255, 3, 8, 1'b1);
    chk("e255_error", 32'(error), 32'h181);
    conv(8'd128, 3, 8, 1'b1);
    chk("e128_error", 32'(error), 32'h000);
    chk("sign_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("sign_valid_cnt", valid_cnt, 32'd4);

    // Timeout in WAIT_RISE: abort exactly on the 64th cycle spent waiting
    vc0 = valid_cnt;
    adc_data = 8'd33;
    convst_bar = 1'b0;
    tick;
    convst_bar = 1'b1;
    repeat (63) tick;
    chk("to_rise_before", 32'(timeout_err), 32'd0);
    tick;
    chk("to_rise_after", 32'(timeout_err), 32'd1);
    chk("to_rise_novalid", valid_cnt, vc0);
    chk("to_rise_sample", 32'(sample), 32'd128);
    flag_clr = 1'b1;
    tick;
    flag_clr = 1'b0;
    chk("to_clr", 32'(timeout_err), 32'd0);

    // Timeout in WAIT_FALL with BUSY stuck high
    busy = 1'b1;
    repeat (4) tick;
    convst_bar = 1'b0;
    tick;
    convst_bar = 1'b1;
    repeat (60) tick;
    chk("to_fall_before", 32'(timeout_err), 32'd0);
    repeat (10) tick;
    chk("to_fall_after", 32'(timeout_err), 32'd1);
    chk("to_fall_novalid", valid_cnt, vc0);
    chk("to_fall_sample", 32'(sample), 32'd128);
    busy = 1'b0;
    repeat (4) tick;
    flag_clr = 1'b1;
    tick;
    flag_clr = 1'b0;

    // Overrun during WAIT_FALL; first conversion still completes
    adc_data = 8'd77;
    sb_q.push_back(8'd77);
    convst_bar = 1'b0;
    tick;
    convst_bar = 1'b1;
    repeat (3) tick;
    busy = 1'b1;
    repeat (5) tick;
    convst_bar = 1'b0;
    tick;
    convst_bar = 1'b1;
    repeat (15) tick;
    busy = 1'b0;
    repeat (10) tick;
    chk("ov_oerr", 32'(overrun_err), 32'd1);
    chk("ov_terr", 32'(timeout_err), 32'd0);
    chk("ov_valid_cnt", valid_cnt, vc0 + 1);
    chk("ov_sample", 32'(sample), 32'd77);
    flag_clr = 1'b1;
    tick;
    flag_clr = 1'b0;
    chk("ov_clr_oerr", 32'(overrun_err), 32'd0);
    chk("ov_clr_terr", 32'(timeout_err), 32'd0);

    // Reset while the read strobe is low
    adc_data = 8'd99;
    convst_bar = 1'b0;
    tick;
    convst_bar = 1'b1;
    repeat (3) tick;
    busy = 1'b1;
    repeat (8) tick;
    busy = 1'b0;
    for (int i = 0; i < 20 && rd_bar !== 1'b0; i++) tick;
    chk("mid_rd_low", 32'(rd_bar), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rd", 32'(rd_bar), 32'd1);
    chk("mid_rst_cs", 32'(cs_bar), 32'd1);
    chk("mid_rst_sample", 32'(sample), 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    chk("mid_rst_valid", 32'(sample_valid), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    conv(8'd55, 4, 10, 1'b1);
    chk("post_rst_sample", 32'(sample), 32'd55);
    chk("post_rst_sb_empty", 32'(sb_q.size()), 32'd0);

    // Back-to-back at the divider rate
    vc0 = valid_cnt;
    for (int k = 1; k <= 3; k++) begin
      conv(8'(k * 10), 2, 20, 1'b1);
      repeat (31) tick;
    end
    chk("b2b_valid_cnt", valid_cnt, vc0 + 3);
    chk("b2b_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("b2b_oerr", 32'(overrun_err), 32'd0);
    chk("b2b_terr", 32'(timeout_err), 32'd0);
    chk("b2b_sample", 32'(sample), 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
